// File: rtl/andornot_pkg.sv
// Shared types and helpers for the and-or-not gate block checker.
package andornot_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrive  = 3'd1,
    StSettle = 3'd2,
    StCheck  = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam int unsigned NUM_VEC = 4;

  // Golden response of the gate block: {and, or, not a}.
  function automatic logic [2:0] expected_y(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/andornot_checker.sv
// Stimulus/response checker: walks a,b through all four vectors, waits a settle
// window, then compares the gate block response against the golden function.
module andornot_checker
  import andornot_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [2:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
  localparam logic [1:0] LastVec    = 2'(NUM_VEC - 1);
  localparam logic [2:0] ErrMax     = 3'(NUM_VEC);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = '0;
          fail_d  = '0;
          vec_d   = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = SettleInit;
        state_d = StSettle;
      end
      StSettle: begin
        // Leaving on the count-of-one edge makes SETTLE last exactly SETTLE_CYCLES.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (y != expected_y(a_q, b_q)) begin
          fail_d[vec_q] = 1'b1;
          if (err_q < ErrMax) begin
            err_d = err_q + 3'd1;
          end
        end
        if (vec_q == LastVec) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign pass      = (state_q == StDone) && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: doc/andornot_checker.md
Name: andornot_checker

Overview:
- Self-clocked stimulus and response checker for the 2-input/3-output and-or-not gate block (y[2]=a&b, y[1]=a|b, y[0]=~a).
- On start, drives a,b through all four combinations, waits a settle window, samples y and compares it against the expected value.
- Reports per-vector failures, a saturating error count and an overall pass flag.
- Sits opposite the gate block: its a/b outputs feed the gate inputs, and its y input takes the gate outputs. Used for on-board self-test and bench regression.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a,b and sampling y; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; sampled only in IDLE or DONE
- a  output  1  stimulus to gate block (registered)
- b  output  1  stimulus to gate block (registered)
- y  input  3  gate block response {and, or, not}
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until next start or rst
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  3  number of failing vectors, saturates at 4
- fail_vec  output  4  bit i set if vector i (a=i[1], b=i[0]) mismatched

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE and all of the following to 0: a, b, busy, done, pass, err_count, fail_vec, vector index, settle counter. rst has priority over start and over all state activity; asserting it mid-run aborts the run immediately with no done pulse.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: start=1 → clear err_count, fail_vec, done and pass; set vec=0; go to DRIVE. start=0 → stay.
- DRIVE: one cycle. a<=vec[1], b<=vec[0], settle counter <= SETTLE_CYCLES, busy=1; go to SETTLE.
- SETTLE: decrement counter each cycle. Advance to CHECK on the edge where the counter reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK: one cycle. Compute expected = {a&b, a|b, ~a} from the registered a,b and compare all 3 bits with y.
  - On mismatch: fail_vec[vec]<=1 and err_count<=err_count+1, saturating at 4.
  - If vec==3 → DONE; otherwise vec<=vec+1 → DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0); a,b hold the last vector. start=1 → same clearing as from IDLE, then DRIVE.
- busy=1 exactly in DRIVE, SETTLE and CHECK. start during busy is ignored, with no effect on any state.
- Timing: if start is sampled at edge 0, done is first observed high after edge 4*(SETTLE_CYCLES+2). With the default that is 16 cycles.
- y is sampled only in CHECK. Glitches on y outside CHECK have no effect.
- err_count and fail_vec update at the CHECK edge and stay stable through DONE.

Decomposition:
- Package andornot_pkg holds:
  - the state encoding constants (IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4, 3-bit);
  - NUM_VEC=4;
  - the function expected_y(a,b) returning {a&b, a|b, ~a}.
- No sub-module; a single FSM plus datapath. The testbench instantiates the existing gate block alongside as the golden device under test.

Test Plan:
1. Fault-free gate block, default SETTLE_CYCLES=2, pulse start → busy high for 16 cycles; done=1, pass=1, err_count=0, fail_vec=4'b0000; a,b step 00,01,10,11 every 4 cycles.
2. y[0] forced to 0 → vectors 0 and 1 fail; fail_vec=4'b0011, err_count=2, pass=0.
3. y[2] forced to 1 → vectors 0,1,2 fail; fail_vec=4'b0111, err_count=3. Then all three outputs forced to 3'b000 and start issued from DONE → fail_vec=4'b1111, err_count=4, earlier result fully cleared.
4. start held high continuously → exactly one run per DONE visit; start pulses mid-run do not change vec or timing (done still at cycle 16).
5. rst asserted during SETTLE of vector 2 → next cycle a=b=0, busy=0, done=0, err_count=0, fail_vec=0; a subsequent start completes normally.
6. SETTLE_CYCLES=1 → done after 12 cycles; gate block fault-free → pass=1.
